// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and single-shot key reporting
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   slow_clk   scan-rate strobe from an upstream divider, sampled as data
//   col_in     keypad columns, active-low, asynchronous to clk
//   row_out    keypad row drive, exactly one bit low
//   key_code   last accepted key, row*4 + col
//   key_valid  one-clk pulse when a new key is accepted
//   key_held   high while the accepted key remains pressed
module keypad_scanner #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] TICKS = DEBOUNCE_TICKS[3:0];

    state_t     state_q, state_d;
    logic [1:0] row_idx_q, row_idx_d;
    logic [1:0] col_idx_q, col_idx_d;
    logic [3:0] col_pat_q, col_pat_d;
    logic [3:0] count_q, count_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;

    logic [3:0] col_s1_q, col_s2_q;
    logic       slow_s1_q, slow_s2_q, slow_prev_q;

    logic       scan_tick;
    logic [3:0] cols;
    logic [3:0] count_inc;
    logic       one_low;
    logic [1:0] col_sel;

    // Synchronizers and slow_clk rising-edge detector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1_q    <= 4'h0;
            col_s2_q    <= 4'h0;
            slow_s1_q   <= 1'b0;
            slow_s2_q   <= 1'b0;
            slow_prev_q <= 1'b0;
        end else begin
            col_s1_q    <= col_in;
            col_s2_q    <= col_s1_q;
            slow_s1_q   <= slow_clk;
            slow_s2_q   <= slow_s1_q;
            slow_prev_q <= slow_s2_q;
        end
    end

    assign scan_tick = slow_s2_q & ~slow_prev_q;
    assign cols      = col_s2_q;
    assign count_inc = (count_q == 4'hF) ? 4'hF : count_q + 4'd1;

    // Only a single low column is a capturable key; anything else is idle or ghosting
    always_comb begin
        one_low = 1'b1;
        col_sel = 2'd0;
        case (cols)
            4'b1110: col_sel = 2'd0;
            4'b1101: col_sel = 2'd1;
            4'b1011: col_sel = 2'd2;
            4'b0111: col_sel = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_SCAN;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            col_pat_q   <= 4'h0;
            count_q     <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            col_pat_q   <= col_pat_d;
            count_q     <= count_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next-state logic; nothing moves except on scan_tick
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        col_pat_d   = col_pat_q;
        count_d     = count_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (scan_tick) begin
            case (state_q)
                S_SCAN: begin
                    if (one_low) begin
                        col_idx_d = col_sel;
                        col_pat_d = cols;
                        count_d   = 4'd1;
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d     = S_PRESSED;
                            key_valid_d = 1'b1;
                            key_code_d  = {row_idx_q, col_sel};
                        end else begin
                            state_d = S_DEBOUNCE;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (cols == col_pat_q) begin
                        count_d = count_inc;
                        if (count_inc >= TICKS) begin
                            state_d     = S_PRESSED;
                            key_valid_d = 1'b1;
                            key_code_d  = {row_idx_q, col_idx_q};
                        end
                    end else begin
                        count_d   = 4'd0;
                        row_idx_d = row_idx_q + 2'd1;
                        state_d   = S_SCAN;
                    end
                end
                S_PRESSED: begin
                    if (cols == 4'b1111) begin
                        count_d = 4'd1;
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d   = S_SCAN;
                            row_idx_d = row_idx_q + 2'd1;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (cols == 4'b1111) begin
                        count_d = count_inc;
                        if (count_inc >= TICKS) begin
                            state_d   = S_SCAN;
                            row_idx_d = row_idx_q + 2'd1;
                        end
                    end else begin
                        // Release bounce: back to held without re-reporting the key
                        count_d = 4'd0;
                        state_d = S_PRESSED;
                    end
                end
                default: state_d = S_SCAN;
            endcase
        end
    end

    // Outputs
    always_comb begin
        row_out   = ~(4'b0001 << row_idx_q);
        key_code  = key_code_q;
        key_valid = key_valid_q;
        key_held  = (state_q == S_PRESSED) || (state_q == S_RELEASE);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with DEBOUNCE_TICKS = 4
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       slow_clk;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Keypad model: one pressed key, or a forced column pattern
    logic       key_on;
    logic [1:0] key_row;
    logic [3:0] key_pat;
    logic       ovr_en;
    logic [3:0] ovr_pat;

    typedef struct {
        logic [3:0] code;
        int         tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   tick_cnt;

    keypad_scanner #(.DEBOUNCE_TICKS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .slow_clk  (slow_clk),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] row_pat(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    assign col_in = ovr_en ? ovr_pat :
                    (key_on && (row_out == row_pat(int'(key_row)))) ? key_pat : 4'hF;

    task automatic tick();
        tick_cnt = tick_cnt + 1;
        @(negedge clk);
        slow_clk = 1'b1;
        repeat (4) @(negedge clk);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;
        tick_cnt = 0;
        rst      = 1'b0;
        slow_clk = 1'b0;
        key_on   = 1'b0;
        key_row  = 2'd0;
        key_pat  = 4'hF;
        ovr_en   = 1'b0;
        ovr_pat  = 4'hF;

        fork
            forever begin
                @(negedge clk);
                if (key_valid === 1'b1) begin
                    checks = checks + 1;
                    if (exp_q.size() == 0) begin
                        failures = failures + 1;
                        $display("FAIL unexpected_key_valid: key_valid=1 code=%0d at tick %0d, required no pulse", key_code, tick_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (key_code !== e.code) begin
                            failures = failures + 1;
                            $display("FAIL key_valid_code: got %0d required %0d", key_code, e.code);
                        end
                        checks = checks + 1;
                        if (tick_cnt != e.tick) begin
                            failures = failures + 1;
                            $display("FAIL key_valid_tick: got tick %0d required tick %0d", tick_cnt, e.tick);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_row_out", row_out, 4'b1110);
        chk("reset_key_code", key_code, 4'h0);
        chk("reset_key_valid", {3'b0, key_valid}, 4'h0);
        chk("reset_key_held", {3'b0, key_held}, 4'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Idle scanning
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("idle_row", row_out, row_pat((k + 1) % 4));
        end

        // Two columns low on row 0: no capture, row advances
        ovr_en  = 1'b1;
        ovr_pat = 4'b1001;
        tick();
        chk("ghost_row", row_out, 4'b1101);
        chk("ghost_held", {3'b0, key_held}, 4'h0);
        ovr_en = 1'b0;
        tick();
        chk("advance_row2", row_out, 4'b1011);

        // Key row 2 col 1 held for 6 ticks
        key_on  = 1'b1;
        key_row = 2'd2;
        key_pat = 4'b1101;
        exp_q.push_back('{code: 4'd9, tick: tick_cnt + 4});
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("press_held", {3'b0, key_held}, (j >= 3) ? 4'h1 : 4'h0);
        end
        chk("press_code", key_code, 4'd9);
        chk("press_row_hold", row_out, 4'b1011);

        // Release with a bounce
        key_on = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("release_held", {3'b0, key_held}, 4'h1);
        end
        key_on = 1'b1;
        tick();
        chk("release_bounce_held", {3'b0, key_held}, 4'h1);
        key_on = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("release_clean_held", {3'b0, key_held}, (j < 3) ? 4'h1 : 4'h0);
        end
        chk("release_row_adv", row_out, 4'b0111);
        chk("release_code_kept", key_code, 4'd9);

        // Press bounce: 2 matches, 1 open, then stable
        key_on = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("bounce_pre_held", {3'b0, key_held}, 4'h0);
        end
        ovr_en  = 1'b1;
        ovr_pat = 4'hF;
        tick();
        ovr_en = 1'b0;
        chk("bounce_abort_row", row_out, 4'b0111);
        chk("bounce_abort_held", {3'b0, key_held}, 4'h0);
        exp_q.push_back('{code: 4'd9, tick: tick_cnt + 7});
        for (int j = 0; j < 7; j++) begin
            tick();
            chk("bounce_held", {3'b0, key_held}, (j == 6) ? 4'h1 : 4'h0);
        end
        key_on = 1'b0;
        repeat (4) tick();
        chk("bounce_release_held", {3'b0, key_held}, 4'h0);
        chk("bounce_release_row", row_out, 4'b0111);

        // Reset asserted mid-DEBOUNCE on row 3 col 0
        key_on  = 1'b1;
        key_row = 2'd3;
        key_pat = 4'b1110;
        tick();
        tick();
        chk("mid_debounce_held", {3'b0, key_held}, 4'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_row", row_out, 4'b1110);
        chk("async_rst_code", key_code, 4'h0);
        chk("async_rst_held", {3'b0, key_held}, 4'h0);
        chk("async_rst_valid", {3'b0, key_valid}, 4'h0);
        key_on = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tick();
        chk("post_rst_row", row_out, 4'b1101);
        chk("post_rst_held", {3'b0, key_held}, 4'h0);

        // Every expected key_valid must have been observed
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL missing_key_valid: %0d pulses outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %b required %b (tick %0d)", name, act, exp, tick_cnt);
        end
    endtask

endmodule
